reg_bus_sched: RTL and testbench

- Two-requester scheduler for the shared register bus of the engine: register accesses use a 2-bit command, a 2-bit address and write data.
- Arbitrates round-robin between requesters and drives one bus transaction at a time.
- Collects read data, and holds the bus after a start write (write to address 0) until the engine signals operation done or a timeout expires.
- Sits between the host-side agents and the engine's register/operation-done logic.

---
 rtl/reg_bus_pkg.sv | 26 ++
 rtl/rr_arb2.sv | 37 +++
 rtl/reg_bus_sched.sv | 131 +++++++++++++
 tb/tb_reg_bus_sched.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_bus_pkg.sv
// Shared types for the engine register-bus scheduler: bus commands,
// scheduler states and the start-operation register address.
package reg_bus_pkg;

  typedef enum logic [1:0] {
    CMD_IDLE = 2'd0,
    CMD_WR   = 2'd1,
    CMD_RD   = 2'd2,
    CMD_RSV  = 2'd3
  } cmd_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_RD_CAP,
    ST_WAIT_DONE,
    ST_ACK
  } sched_state_t;

  localparam logic [1:0] START_ADDR = 2'b00;

  function automatic logic cmd_legal(input logic [1:0] cmd);
    return (cmd == CMD_WR) || (cmd == CMD_RD);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the pointer remembers which requester was
// served last so the other one wins the next tie.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt,
  output logic       vld
);

  logic last_q;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = last_q ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  assign vld = |gnt;

  // Reset to 1 so requester 0 wins the very first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= 1'b1;
    end else if (vld) begin
      last_q <= gnt[1];
    end
  end

endmodule

// File: rtl/reg_bus_sched.sv
// Two-requester scheduler for the engine register bus: one transaction at a
// time, read-data capture, and bus hold after a start write until done/timeout.
module reg_bus_sched
  import reg_bus_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req_i,
  input  logic [1:0]        cmd0_i,
  input  logic [1:0]        addr0_i,
  input  logic [DATA_W-1:0] wdata0_i,
  input  logic [1:0]        cmd1_i,
  input  logic [1:0]        addr1_i,
  input  logic [DATA_W-1:0] wdata1_i,
  output logic [1:0]        ack_o,
  output logic              err_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic [1:0]        bus_rd_wr_id_o,
  output logic [1:0]        bus_addr_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  input  logic [DATA_W-1:0] bus_rdata_i,
  input  logic              engine_done_i,
  output logic              busy_o
);

  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYC - 1);

  sched_state_t      state_q, state_d;
  logic [1:0]        masked_req, arb_gnt, gnt_q;
  logic              arb_vld, timeout, issue_legal;
  logic [1:0]        cmd_q, addr_q;
  logic [DATA_W-1:0] wdata_q, rd_hold_q;
  logic              err_q;
  logic [31:0]       cnt_q;

  // The requester acked this cycle still holds req; it must not be re-granted.
  assign masked_req = req_i & ~ack_o;

  rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .req (masked_req),
    .en  (state_q == ST_IDLE),
    .gnt (arb_gnt),
    .vld (arb_vld)
  );

  always_comb begin
    state_d = state_q;
    timeout = 1'b0;
    case (state_q)
      ST_IDLE:      if (arb_vld) state_d = ST_ISSUE;
      ST_ISSUE: begin
        if (!cmd_legal(cmd_q))       state_d = ST_ACK;
        else if (cmd_q == CMD_RD)    state_d = ST_RD_CAP;
        else if (addr_q == START_ADDR) state_d = ST_WAIT_DONE;
        else                         state_d = ST_ACK;
      end
      ST_RD_CAP:    state_d = ST_ACK;
      ST_WAIT_DONE: begin
        if (engine_done_i) begin
          state_d = ST_ACK;
        end else if ((TIMEOUT_CYC > 0) && (cnt_q == TO_LAST)) begin
          state_d = ST_ACK;
          timeout = 1'b1;
        end
      end
      ST_ACK:       state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // Bus is driven only while issuing a legal command; otherwise it rests at 0.
  assign issue_legal    = (state_q == ST_ISSUE) && cmd_legal(cmd_q);
  assign bus_rd_wr_id_o = issue_legal ? cmd_q   : 2'b00;
  assign bus_addr_o     = issue_legal ? addr_q  : 2'b00;
  assign bus_wdata_o    = issue_legal ? wdata_q : '0;
  assign busy_o         = (state_q != ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= 2'b00;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      ack_o   <= 2'b00;
      err_o   <= 1'b0;
      rdata_o <= '0;
    end else begin
      state_q <= state_d;
      ack_o   <= 2'b00;
      err_o   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (arb_vld) begin
            gnt_q <= arb_gnt;
            err_q <= 1'b0;
          end
        end
        ST_ISSUE: begin
          // WAIT_DONE is only entered from here, so this is the entry clear.
          cnt_q <= '0;
          if (!cmd_legal(cmd_q)) err_q <= 1'b1;
        end
        ST_WAIT_DONE: begin
          cnt_q <= cnt_q + 32'd1;
          if (timeout) err_q <= 1'b1;
        end
        ST_ACK: begin
          ack_o <= gnt_q;
          err_o <= err_q;
          if (cmd_q == CMD_RD) rdata_o <= rd_hold_q;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if ((state_q == ST_IDLE) && arb_vld) begin
      cmd_q   <= arb_gnt[1] ? cmd1_i   : cmd0_i;
      addr_q  <= arb_gnt[1] ? addr1_i  : addr0_i;
      wdata_q <= arb_gnt[1] ? wdata1_i : wdata0_i;
    end
    if (state_q == ST_RD_CAP) rd_hold_q <= bus_rdata_i;
  end

endmodule

// File: tb/tb_reg_bus_sched.sv
// Bench for reg_bus_sched: directed plan items plus randomized single
// transactions checked against a transaction-level model and engine model.
module tb_reg_bus_sched;

  localparam int DW = 32;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    req;
  logic [1:0]    cmd0, addr0, cmd1, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic [1:0]    ack_o;
  logic          err_o;
  logic [DW-1:0] rdata_o;
  logic [1:0]    bus_rd_wr_id_o, bus_addr_o;
  logic [DW-1:0] bus_wdata_o;
  logic [DW-1:0] bus_rdata_i;
  logic          engine_done;
  logic          busy_o;

  reg_bus_sched #(.DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_i          (req),
    .cmd0_i         (cmd0),
    .addr0_i        (addr0),
    .wdata0_i       (wdata0),
    .cmd1_i         (cmd1),
    .addr1_i        (addr1),
    .wdata1_i       (wdata1),
    .ack_o          (ack_o),
    .err_o          (err_o),
    .rdata_o        (rdata_o),
    .bus_rd_wr_id_o (bus_rd_wr_id_o),
    .bus_addr_o     (bus_addr_o),
    .bus_wdata_o    (bus_wdata_o),
    .bus_rdata_i    (bus_rdata_i),
    .engine_done_i  (engine_done),
    .busy_o         (busy_o)
  );

  always #5 clk = ~clk;

  // Engine register file: applies bus writes, answers reads one cycle later,
  // and returns junk whenever no read is on the bus.
  logic [DW-1:0] eng_regs [4];
  always @(posedge clk) begin
    if (bus_rd_wr_id_o == 2'd1) eng_regs[bus_addr_o] <= bus_wdata_o;
    bus_rdata_i <= (bus_rd_wr_id_o == 2'd2) ? eng_regs[bus_addr_o] : $urandom;
  end

  int passed = 0;
  int total  = 0;

  // Reference model state
  logic [DW-1:0] shadow [4];
  logic [DW-1:0] exp_rdata;
  int            last;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int r, input logic [1:0] c, input logic [1:0] a, input logic [DW-1:0] wd);
    if (r == 0) begin
      cmd0 = c; addr0 = a; wdata0 = wd;
      cmd1 = 2'($urandom); addr1 = 2'($urandom); wdata1 = $urandom;
    end else begin
      cmd1 = c; addr1 = a; wdata1 = wd;
      cmd0 = 2'($urandom); addr0 = 2'($urandom); wdata0 = $urandom;
    end
    req[r] = 1'b1;
  endtask

  // One transaction from a lone requester. j = cycle index within WAIT_DONE
  // at which done pulses for a start write, or -1 for no done (timeout).
  task automatic run_txn(input int r, input logic [1:0] c, input logic [1:0] a,
                         input logic [DW-1:0] wd, input int j, input bit drop_early, input bit spur);
    bit   legal, is_rd, is_start, exp_err;
    int   exp_k, k;
    logic [1:0] a_seen;
    logic       e_seen;
    legal    = (c == 2'd1) || (c == 2'd2);
    is_rd    = (c == 2'd2);
    is_start = (c == 2'd1) && (a == 2'd0);
    exp_err  = !legal || (is_start && j < 0);
    exp_k    = !legal ? 3 : is_rd ? 4 : is_start ? ((j < 0) ? 3 + TO : 4 + j) : 3;
    if (is_rd) exp_rdata = shadow[a];
    else if (legal) shadow[a] = wd;

    set_req(r, c, a, wd);
    k = 0; a_seen = 2'b00; e_seen = 1'b0;
    while (a_seen == 2'b00 && k < 40) begin
      step();
      k++;
      engine_done = (is_start && j >= 0 && k == 2 + j) || (spur && k == 1) ||
                    (spur && !is_start && k == 2);
      if (k == 1) begin
        check("issue_cmd",   bus_rd_wr_id_o, legal ? c : 2'd0);
        check("issue_addr",  bus_addr_o,     legal ? a : 2'd0);
        check("issue_wdata", bus_wdata_o,    legal ? wd : 32'd0);
        check("issue_busy",  busy_o, 1'b1);
        if (drop_early) req[r] = 1'b0;
      end
      if (k == 2) check("bus_idle", bus_rd_wr_id_o, 2'd0);
      a_seen = ack_o;
      e_seen = err_o;
    end
    engine_done = 1'b0;
    check("ack_latency", k, exp_k);
    check("ack_who", a_seen, (r == 1) ? 2'b10 : 2'b01);
    check("ack_err", e_seen, exp_err);
    check("rdata", rdata_o, exp_rdata);
    last = r;
    req[r] = 1'b0;
    step();
    check("no_regrant_busy", busy_o, 1'b0);
    check("ack_one_cycle", ack_o, 2'b00);
  endtask

  initial begin
    int k, nacks, prev_k, exp_w, bad;
    logic [DW-1:0] w0, w1, ws, wx;
    rst = 1'b1; req = 2'b00; engine_done = 1'b0;
    cmd0 = 0; addr0 = 0; wdata0 = 0; cmd1 = 0; addr1 = 0; wdata1 = 0;
    last = 1; exp_rdata = '0;
    for (int i = 0; i < 4; i++) shadow[i] = '0;
    step(); step(); step();
    check("rst_ack",   ack_o, 2'b00);
    check("rst_err",   err_o, 1'b0);
    check("rst_rdata", rdata_o, 32'd0);
    check("rst_bus",   {bus_rd_wr_id_o, bus_addr_o, bus_wdata_o}, 36'd0);
    check("rst_busy",  busy_o, 1'b0);
    rst = 1'b0;
    step();

    // Both requesting continuously: grants alternate starting with 0.
    w0 = $urandom; w1 = $urandom;
    cmd0 = 2'd1; addr0 = 2'd1; wdata0 = w0;
    cmd1 = 2'd1; addr1 = 2'd2; wdata1 = w1;
    req = 2'b11;
    exp_w = (last == 1) ? 0 : 1;
    nacks = 0; k = 0; prev_k = 0;
    while (nacks < 4 && k < 60) begin
      step();
      k++;
      if (ack_o != 2'b00) begin
        check("tie_who", ack_o, (exp_w == 1) ? 2'b10 : 2'b01);
        check("tie_err", err_o, 1'b0);
        check("tie_gap", k - prev_k, 3);
        prev_k = k;
        last = exp_w;
        if (exp_w == 1) shadow[2] = w1; else shadow[1] = w0;
        exp_w = 1 - exp_w;
        nacks++;
      end
    end
    check("tie_count", nacks, 4);
    req = 2'b00;
    step();
    check("tie_idle", busy_o, 1'b0);

    // Directed plan items
    run_txn(0, 2'd1, 2'd2, 32'hA5, 0, 0, 0);
    run_txn(0, 2'd1, 2'd3, 32'h1234, 0, 0, 0);
    run_txn(1, 2'd2, 2'd3, 32'h0, 0, 0, 0);
    run_txn(0, 2'd1, 2'd1, 32'hBEEF, 0, 0, 1);
    run_txn(0, 2'd1, 2'd0, 32'h5555, -1, 0, 0);
    run_txn(1, 2'd3, 2'd1, 32'hDEAD, 0, 0, 0);
    run_txn(0, 2'd0, 2'd2, 32'hCAFE, 0, 1, 0);

    // Start write with done one cycle later; requester 1 queues behind it.
    ws = $urandom; wx = $urandom;
    set_req(0, 2'd1, 2'd0, ws);
    step();
    check("start_busy1", busy_o, 1'b1);
    cmd1 = 2'd1; addr1 = 2'd1; wdata1 = wx; req[1] = 1'b1;
    step();
    engine_done = 1'b1;
    check("start_busy2", busy_o, 1'b1);
    check("start_noack2", ack_o, 2'b00);
    step();
    engine_done = 1'b0;
    check("start_busy3", busy_o, 1'b1);
    check("start_noack3", ack_o, 2'b00);
    step();
    check("start_ack", ack_o, 2'b01);
    check("start_err", err_o, 1'b0);
    req[0] = 1'b0;
    step(); step();
    check("queued_wait", ack_o, 2'b00);
    step();
    check("queued_ack", ack_o, 2'b10);
    check("queued_err", err_o, 1'b0);
    req[1] = 1'b0;
    shadow[0] = ws; shadow[1] = wx; last = 1;
    step();

    // Randomized single transactions
    for (int n = 0; n < 24; n++) begin
      int r, sel, j;
      logic [1:0] c, a;
      r = $urandom_range(0, 1);
      sel = $urandom_range(0, 9);
      a = 2'($urandom);
      j = 0;
      if (sel == 0) c = 2'd0;
      else if (sel == 1) c = 2'd3;
      else if (sel <= 4) c = 2'd2;
      else if (sel <= 7) c = 2'd1;
      else begin
        c = 2'd1; a = 2'd0;
        j = $urandom_range(0, 6);
        if (j == 6) j = -1;
      end
      run_txn(r, c, a, $urandom, j, 1'($urandom), 1'($urandom));
    end

    // Reset during WAIT_DONE aborts the transaction with no ack.
    ws = $urandom;
    set_req(0, 2'd1, 2'd0, ws);
    shadow[0] = ws;
    step(); step(); step();
    #2 rst = 1'b1;
    #1;
    check("abort_ack",   ack_o, 2'b00);
    check("abort_err",   err_o, 1'b0);
    check("abort_rdata", rdata_o, 32'd0);
    check("abort_bus",   {bus_rd_wr_id_o, bus_addr_o, bus_wdata_o}, 36'd0);
    check("abort_busy",  busy_o, 1'b0);
    req = 2'b00;
    step(); step();
    rst = 1'b0;
    last = 1; exp_rdata = '0;
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (ack_o != 2'b00 || busy_o) bad++;
    end
    check("abort_quiet", bad, 0);
    run_txn(1, 2'd2, 2'd0, 32'h0, 0, 0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
